// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    localparam logic [CNT_W-1:0] ITER_LAST = 5'd15;
    localparam logic [CNT_W-1:0] CNT_ONE   = 5'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/trial_sub17.sv
// Combinational trial subtraction a + ~b + 1 using 4-bit look-ahead carry groups.
module trial_sub17 #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         no_borrow
);

    localparam int NG = (N + 3) / 4;

    logic [N-1:0]  bn_s;
    logic [N-1:0]  g_s;
    logic [N-1:0]  p_s;
    logic [N-1:0]  c_s;
    logic [NG-1:0] gg_s;
    logic [NG-1:0] gp_s;
    logic [NG:0]   gc_s;

    // Group generate/propagate, inter-group look-ahead, then in-group carries.
    always_comb begin
        bn_s = ~b;
        g_s  = a & bn_s;
        p_s  = a ^ bn_s;
        gg_s = {NG{1'b0}};
        gp_s = {NG{1'b1}};
        gc_s = {(NG+1){1'b0}};
        c_s  = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            gg_s[i/4] = g_s[i] | (p_s[i] & gg_s[i/4]);
            gp_s[i/4] = gp_s[i/4] & p_s[i];
        end
        // Carry-in of 1 supplies the +1 of the two's complement.
        gc_s[0] = 1'b1;
        for (int k = 0; k < NG; k++) begin
            gc_s[k+1] = gg_s[k] | (gp_s[k] & gc_s[k]);
        end
        for (int i = 0; i < N; i++) begin
            if ((i % 4) == 0) begin
                c_s[i] = gc_s[i/4];
            end else begin
                c_s[i] = g_s[i-1] | (p_s[i-1] & c_s[i-1]);
            end
        end
        diff      = p_s ^ c_s;
        no_borrow = gc_s[NG];
    end

endmodule

// File: rtl/seq_divider16.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/done handshake.
module seq_divider16
    import div_pkg::*;
#(
    parameter int WIDTH = div_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t           state_r;
    state_t           state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] q_nx_s;
    logic [WIDTH-1:0] r_nx_s;
    logic [WIDTH:0]   r_shift_s;
    logic [WIDTH:0]   diff_s;
    logic             no_borrow_s;
    logic             div_zero_s;
    logic             unused_diff_msb_s;

    // R' is 17 bits so a shifted-out MSB still takes part in the trial subtraction.
    assign r_shift_s         = {r_r, q_r[WIDTH-1]};
    assign div_zero_s        = (divisor == {WIDTH{1'b0}});
    assign unused_diff_msb_s = diff_s[WIDTH];

    trial_sub17 #(
        .N (WIDTH + 1)
    ) u_trial_sub (
        .a         (r_shift_s),
        .b         ({1'b0, d_r}),
        .diff      (diff_s),
        .no_borrow (no_borrow_s)
    );

    // Restore-or-keep selection for one iteration.
    always_comb begin
        q_nx_s = {q_r[WIDTH-2:0], no_borrow_s};
        if (no_borrow_s) begin
            r_nx_s = diff_s[WIDTH-1:0];
        end else begin
            r_nx_s = r_shift_s[WIDTH-1:0];
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && div_zero_s) begin
                    state_nx_s = DONE;
                end else if (start) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == ITER_LAST) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register plus registered status flags derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy    <= (state_nx_s == RUN);
            done    <= (state_nx_s == DONE);
        end
    end

    // Datapath: operand capture, iteration, and result publication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= {CNT_W{1'b0}};
            q_r         <= {WIDTH{1'b0}};
            r_r         <= {WIDTH{1'b0}};
            d_r         <= {WIDTH{1'b0}};
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && div_zero_s) begin
                        quotient    <= {WIDTH{1'b1}};
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                    end else if (start) begin
                        d_r   <= divisor;
                        q_r   <= dividend;
                        r_r   <= {WIDTH{1'b0}};
                        cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                RUN: begin
                    q_r   <= q_nx_s;
                    r_r   <= r_nx_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == ITER_LAST) begin
                        quotient    <= q_nx_s;
                        remainder   <= r_nx_s;
                        div_by_zero <= 1'b0;
                    end else begin
                        div_by_zero <= div_by_zero;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider16.sv
// Directed-vector bench for seq_divider16 with a cycle-level arithmetic reference model.
module tb_seq_divider16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = 16'd0;
    logic [15:0] divisor = 16'd0;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    seq_divider16 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: results from / and %, timing as cycles left until idle again.
    logic [15:0] m_q, m_r, pend_q, pend_r;
    logic        m_busy, m_done, m_dbz;
    int          left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q <= 16'd0; m_r <= 16'd0; m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
            pend_q <= 16'd0; pend_r <= 16'd0; left <= 0;
        end else if (left == 0) begin
            m_done <= 1'b0;
            if (start && divisor == 16'd0) begin
                m_q <= 16'hFFFF; m_r <= dividend; m_dbz <= 1'b1; m_done <= 1'b1; left <= 1;
            end else if (start) begin
                pend_q <= dividend / divisor; pend_r <= dividend % divisor;
                m_busy <= 1'b1; left <= 17;
            end
        end else begin
            left <= left - 1;
            if (left == 2) begin
                m_busy <= 1'b0; m_done <= 1'b1; m_q <= pend_q; m_r <= pend_r; m_dbz <= 1'b0;
            end else if (left == 1) begin
                m_done <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
            check("cyc_done", {31'd0, done}, {31'd0, m_done});
            check("cyc_dbz", {31'd0, div_by_zero}, {31'd0, m_dbz});
            check("cyc_quotient", {16'd0, quotient}, {16'd0, m_q});
            check("cyc_remainder", {16'd0, remainder}, {16'd0, m_r});
        end
    end

    task automatic do_start(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // n0 = posedges since the accepting edge already elapsed (1 right after do_start).
    task automatic wait_done(input string name, input int n0, input int lat);
        int n = n0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done_within_40", name);
        end else begin
            check({name, "_latency"}, n, lat);
        end
    endtask

    task automatic run_div(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] eq, input logic [15:0] er, input logic ez,
                           input int lat);
        do_start(a, b);
        wait_done(name, 1, lat);
        check({name, "_q"}, {16'd0, quotient}, {16'd0, eq});
        check({name, "_r"}, {16'd0, remainder}, {16'd0, er});
        check({name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_q", {16'd0, quotient}, 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_div("d100_7",     16'd100,  16'd7,     16'd14,   16'd2,     1'b0, 17);
        run_div("dffff_1",    16'hFFFF, 16'd1,     16'hFFFF, 16'd0,     1'b0, 17);
        run_div("d8000_8000", 16'h8000, 16'h8000,  16'd1,    16'd0,     1'b0, 17);
        run_div("dffff_8001", 16'hFFFF, 16'h8001,  16'd1,    16'h7FFE,  1'b0, 17);
        run_div("d3_10",      16'd3,    16'd10,    16'd0,    16'd3,     1'b0, 17);
        run_div("d5_0",       16'd5,    16'd0,     16'hFFFF, 16'd5,     1'b1, 1);

        // Stray start with different operands at E5 must be ignored.
        do_start(16'd1234, 16'd10);
        repeat (4) @(negedge clk);
        dividend = 16'd50; divisor = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", 6, 17);
        check("ignore_q", {16'd0, quotient}, 32'd123);
        check("ignore_r", {16'd0, remainder}, 32'd4);
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-RUN clears outputs without waiting for a clock.
        do_start(16'd1234, 16'd10);
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_q", {16'd0, quotient}, 32'd0);
        check("arst_r", {16'd0, remainder}, 32'd0);
        check("arst_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div("d1000_33", 16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 17);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
